// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, trap causes,
// opcodes, datapath mux selects and SYSTEM funct3 values.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  localparam logic [1:0] TRAP_CAUSE_NONE    = 2'd0;
  localparam logic [1:0] TRAP_CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_CAUSE_BUS     = 2'd2;
  localparam logic [1:0] TRAP_CAUSE_ENV     = 2'd3;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] ALU_A_NONE = 2'd0;
  localparam logic [1:0] ALU_A_RD1  = 2'd1;
  localparam logic [1:0] ALU_A_PC   = 2'd2;
  localparam logic [1:0] ALU_A_RS1  = 2'd3;

  localparam logic [1:0] ALU_B_NONE = 2'd0;
  localparam logic [1:0] ALU_B_RD2  = 2'd1;
  localparam logic [1:0] ALU_B_IMM  = 2'd2;
  localparam logic [1:0] ALU_B_CSR  = 2'd3;

  localparam logic [2:0] WD_NONE = 3'd0;
  localparam logic [2:0] WD_ALU  = 3'd1;
  localparam logic [2:0] WD_LOAD = 3'd2;
  localparam logic [2:0] WD_JUMP = 3'd3;
  localparam logic [2:0] WD_LUI  = 3'd4;
  localparam logic [2:0] WD_CSR  = 3'd5;

  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_RSVD   = 3'b100;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Only the opcode and the SYSTEM funct3 decide legality; other funct3 values pass.
  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3,
                                    input logic enable_csr);
    is_legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: is_legal = 1'b1;
      OPC_SYSTEM: begin
        if (funct3 == F3_PRIV)      is_legal = 1'b1;
        else if (funct3 == F3_RSVD) is_legal = 1'b0;
        else                        is_legal = enable_csr;
      end
      default: is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_decode_table.sv
// Per-state datapath mux selects for the multi-cycle control unit, decoded from the
// current state and the opcode/funct3 captured at the end of DECODE.
module control_decode_table
  import multicycle_control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode_q,
  input  logic [2:0] funct3_q,
  output logic [1:0] alu_src_A_select,
  output logic [1:0] alu_src_B_select,
  output logic [2:0] csr_op,
  output logic       register_file_write,
  output logic [2:0] register_file_write_data_select,
  output logic       jump,
  output logic       branch,
  output logic       memory_read,
  output logic       memory_write
);

  always_comb begin
    alu_src_A_select                = ALU_A_NONE;
    alu_src_B_select                = ALU_B_NONE;
    csr_op                          = 3'd0;
    register_file_write             = 1'b0;
    register_file_write_data_select = WD_NONE;
    jump                            = 1'b0;
    branch                          = 1'b0;
    memory_read                     = 1'b0;
    memory_write                    = 1'b0;
    case (state)
      S_EXECUTE: begin
        case (opcode_q)
          OPC_AUIPC, OPC_JAL: begin
            alu_src_A_select = ALU_A_PC;
            alu_src_B_select = ALU_B_IMM;
          end
          OPC_JALR, OPC_LOAD, OPC_STORE, OPC_OP_IMM: begin
            alu_src_A_select = ALU_A_RD1;
            alu_src_B_select = ALU_B_IMM;
          end
          OPC_BRANCH: begin
            alu_src_A_select = ALU_A_RD1;
            alu_src_B_select = ALU_B_RD2;
            branch           = 1'b1;
          end
          OPC_OP: begin
            alu_src_A_select = ALU_A_RD1;
            alu_src_B_select = ALU_B_RD2;
          end
          OPC_SYSTEM: begin
            // Immediate CSR forms (funct3[2]=1) feed the zero-extended rs1 field.
            alu_src_A_select = funct3_q[2] ? ALU_A_RS1 : ALU_A_RD1;
            alu_src_B_select = ALU_B_CSR;
            csr_op           = funct3_q;
          end
          default: ;
        endcase
      end
      S_MEMORY: begin
        memory_read  = (opcode_q == OPC_LOAD);
        memory_write = (opcode_q == OPC_STORE);
      end
      S_WRITEBACK: begin
        register_file_write = 1'b1;
        case (opcode_q)
          OPC_LUI:           register_file_write_data_select = WD_LUI;
          OPC_LOAD:          register_file_write_data_select = WD_LOAD;
          OPC_JAL, OPC_JALR: begin
            register_file_write_data_select = WD_JUMP;
            jump                            = 1'b1;
          end
          OPC_SYSTEM: begin
            register_file_write_data_select = WD_CSR;
            csr_op                          = funct3_q;
          end
          default:           register_file_write_data_select = WD_ALU;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: steps each instruction through FETCH..WRITEBACK,
// runs the memory handshakes with a timeout, raises traps and pulses instret on retire.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter bit ENABLE_CSR  = 1'b0,
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       env_break,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       jump,
  output logic       branch,
  output logic [1:0] alu_src_A_select,
  output logic [1:0] alu_src_B_select,
  output logic [2:0] csr_op,
  output logic       register_file_write,
  output logic [2:0] register_file_write_data_select,
  output logic       memory_read,
  output logic       memory_write,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       instret,
  output logic [2:0] state
);

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_t                state_q;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic [6:0]            opcode_q;
  logic [2:0]            funct3_q;
  logic                  break_q;
  logic [1:0]            trap_cause_q;
  logic                  timeout_hit;
  logic                  decode_legal;
  logic                  decode_env;
  logic                  decode_fence;
  logic                  retire;
  logic                  unused_break;

  assign timeout_hit  = (wait_cnt == WAIT_LAST);
  assign decode_legal = is_legal(opcode, funct3, ENABLE_CSR);
  assign decode_env   = (opcode == OPC_SYSTEM) && (funct3 == F3_PRIV);
  assign decode_fence = (opcode == OPC_MISC_MEM);
  // ECALL and EBREAK share a cause today; the latched bit is kept for the trap handler path.
  assign unused_break = break_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wait_cnt     <= '0;
      opcode_q     <= '0;
      funct3_q     <= '0;
      break_q      <= 1'b0;
      trap_cause_q <= TRAP_CAUSE_NONE;
    end else begin
      wait_cnt <= '0;
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_DECODE;
          end else if (timeout_hit) begin
            state_q      <= S_TRAP;
            trap_cause_q <= TRAP_CAUSE_BUS;
          end else begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
          end
        end
        S_DECODE: begin
          opcode_q <= opcode;
          funct3_q <= funct3;
          break_q  <= env_break;
          if (!decode_legal) begin
            state_q      <= S_TRAP;
            trap_cause_q <= TRAP_CAUSE_ILLEGAL;
          end else if (decode_env) begin
            state_q      <= S_TRAP;
            trap_cause_q <= TRAP_CAUSE_ENV;
          end else if (decode_fence) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (opcode_q == OPC_LOAD || opcode_q == OPC_STORE) state_q <= S_MEMORY;
          else if (opcode_q == OPC_BRANCH)                  state_q <= S_FETCH;
          else                                               state_q <= S_WRITEBACK;
        end
        S_MEMORY: begin
          if (dmem_ack) begin
            state_q <= (opcode_q == OPC_STORE) ? S_FETCH : S_WRITEBACK;
          end else if (timeout_hit) begin
            state_q      <= S_TRAP;
            trap_cause_q <= TRAP_CAUSE_BUS;
          end else begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
          end
        end
        S_WRITEBACK: state_q <= S_FETCH;
        S_TRAP:      state_q <= S_FETCH;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake: a req stays high for the whole FETCH/MEMORY state; the transfer completes in
  // the first cycle its ack is seen with req high, and acks while req is low are ignored.
  assign imem_req = (state_q == S_FETCH);
  assign dmem_req = (state_q == S_MEMORY);
  assign ir_write = (state_q == S_FETCH) && imem_ack;

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_DECODE:    retire = decode_fence;
      S_EXECUTE:   retire = (opcode_q == OPC_BRANCH);
      S_MEMORY:    retire = dmem_ack && (opcode_q == OPC_STORE);
      S_WRITEBACK: retire = 1'b1;
      default:     retire = 1'b0;
    endcase
  end

  assign trap       = (state_q == S_TRAP);
  assign pc_write   = retire || trap;
  assign instret    = retire;
  assign trap_cause = trap_cause_q;
  assign state      = state_q;

  control_decode_table u_decode (
    .state                           (state_q),
    .opcode_q                        (opcode_q),
    .funct3_q                        (funct3_q),
    .alu_src_A_select                (alu_src_A_select),
    .alu_src_B_select                (alu_src_B_select),
    .csr_op                          (csr_op),
    .register_file_write             (register_file_write),
    .register_file_write_data_select (register_file_write_data_select),
    .jump                            (jump),
    .branch                          (branch),
    .memory_read                     (memory_read),
    .memory_write                    (memory_write)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: a per-instruction cycle model builds the
// expected output trace and the ack stimulus, which is then replayed against the DUT.
module tb_multicycle_control_unit;

  localparam int TMO = 4;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEMORY = 3'd4, ST_WRITEBACK = 3'd5, ST_TRAP = 3'd6;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OP_IMM = 7'b0010011, OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] A_RD1 = 2'd1, A_PC = 2'd2;
  localparam logic [1:0] B_RD2 = 2'd1, B_IMM = 2'd2;
  localparam logic [2:0] WD_ALU = 3'd1, WD_LOAD = 3'd2, WD_JUMP = 3'd3, WD_LUI = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       env_break = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, ir_write, pc_write, jump, branch;
  logic [1:0] alu_src_A_select, alu_src_B_select;
  logic [2:0] csr_op;
  logic       register_file_write;
  logic [2:0] register_file_write_data_select;
  logic       memory_read, memory_write, trap;
  logic [1:0] trap_cause;
  logic       instret;
  logic [2:0] state;

  multicycle_control_unit #(.ENABLE_CSR(1'b0), .MEM_TIMEOUT(TMO), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .env_break(env_break),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .ir_write(ir_write), .pc_write(pc_write), .jump(jump), .branch(branch),
    .alu_src_A_select(alu_src_A_select), .alu_src_B_select(alu_src_B_select),
    .csr_op(csr_op), .register_file_write(register_file_write),
    .register_file_write_data_select(register_file_write_data_select),
    .memory_read(memory_read), .memory_write(memory_write), .trap(trap),
    .trap_cause(trap_cause), .instret(instret), .state(state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, dmem_req, ir_write, pc_write, jump, branch;
    logic [1:0] alu_a, alu_b;
    logic [2:0] csr_op;
    logic       rf_write;
    logic [2:0] wd_sel;
    logic       mem_read, mem_write, trap;
    logic [1:0] cause;
    logic       instret;
  } obs_t;

  typedef struct packed {
    obs_t exp;
    logic iack;
    logic dack;
  } step_t;

  step_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] cur_cause = 2'd0;
  logic [6:0] legal_ops [11] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                 OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM};

  function automatic obs_t sample();
    return {state, imem_req, dmem_req, ir_write, pc_write, jump, branch, alu_src_A_select,
            alu_src_B_select, csr_op, register_file_write, register_file_write_data_select,
            memory_read, memory_write, trap, trap_cause, instret};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_rv32i(input logic [6:0] v);
    for (int i = 0; i < 11; i++) if (legal_ops[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] v;
    do v = 7'($urandom_range(0, 127)); while (is_rv32i(v));
    return v;
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.cause = cur_cause;
    return o;
  endfunction

  task automatic push(input obs_t o, input logic ia, input logic da);
    step_t s;
    s.exp = o; s.iack = ia; s.dack = da;
    exp_q.push_back(s);
  endtask

  task automatic push_trap(input logic [1:0] cause);
    obs_t o;
    cur_cause = cause;
    o = base(ST_TRAP);
    o.trap = 1'b1;
    o.pc_write = 1'b1;
    push(o, rbit(), rbit());
  endtask

  // Reference: expected cycle-by-cycle behaviour of one instruction starting in FETCH.
  // fwait/dwait = ack-free cycles before the ack; TMO or more means the bus times out.
  task automatic model_instr(input logic [6:0] opc, input logic [2:0] f3, input int fwait,
                             input int dwait);
    obs_t o;
    for (int i = 0; i < fwait && i < TMO; i++) begin
      o = base(ST_FETCH); o.imem_req = 1'b1; push(o, 1'b0, rbit());
    end
    if (fwait >= TMO) begin push_trap(2'd2); return; end
    o = base(ST_FETCH); o.imem_req = 1'b1; o.ir_write = 1'b1; push(o, 1'b1, rbit());
    o = base(ST_DECODE);
    if (!is_rv32i(opc) || (opc == OPC_SYSTEM && f3 != 3'b000)) begin
      push(o, rbit(), rbit()); push_trap(2'd1); return;
    end
    if (opc == OPC_SYSTEM) begin push(o, rbit(), rbit()); push_trap(2'd3); return; end
    if (opc == OPC_FENCE) begin
      o.pc_write = 1'b1; o.instret = 1'b1; push(o, rbit(), rbit()); return;
    end
    push(o, rbit(), rbit());
    o = base(ST_EXECUTE);
    case (opc)
      OPC_LUI: ;
      OPC_AUIPC, OPC_JAL: begin o.alu_a = A_PC; o.alu_b = B_IMM; end
      OPC_BRANCH: begin
        o.alu_a = A_RD1; o.alu_b = B_RD2; o.branch = 1'b1; o.pc_write = 1'b1; o.instret = 1'b1;
      end
      OPC_OP: begin o.alu_a = A_RD1; o.alu_b = B_RD2; end
      default: begin o.alu_a = A_RD1; o.alu_b = B_IMM; end
    endcase
    push(o, rbit(), rbit());
    if (opc == OPC_BRANCH) return;
    if (opc == OPC_LOAD || opc == OPC_STORE) begin
      for (int i = 0; i < dwait && i < TMO; i++) begin
        o = base(ST_MEMORY); o.dmem_req = 1'b1;
        o.mem_read = (opc == OPC_LOAD); o.mem_write = (opc == OPC_STORE);
        push(o, rbit(), 1'b0);
      end
      if (dwait >= TMO) begin push_trap(2'd2); return; end
      o = base(ST_MEMORY); o.dmem_req = 1'b1;
      o.mem_read = (opc == OPC_LOAD); o.mem_write = (opc == OPC_STORE);
      if (opc == OPC_STORE) begin o.pc_write = 1'b1; o.instret = 1'b1; end
      push(o, rbit(), 1'b1);
      if (opc == OPC_STORE) return;
    end
    o = base(ST_WRITEBACK);
    o.rf_write = 1'b1; o.pc_write = 1'b1; o.instret = 1'b1;
    case (opc)
      OPC_LUI:           o.wd_sel = WD_LUI;
      OPC_LOAD:          o.wd_sel = WD_LOAD;
      OPC_JAL, OPC_JALR: begin o.wd_sel = WD_JUMP; o.jump = 1'b1; end
      default:           o.wd_sel = WD_ALU;
    endcase
    push(o, rbit(), rbit());
  endtask

  // ---------------- driver ----------------
  // Entered and left at posedge+1: drives acks, compares at the falling edge.
  task automatic run_queue(input string name);
    step_t s;
    obs_t  got;
    int    n;
    n = 0;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      imem_ack = s.iack;
      dmem_ack = s.dack;
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s step %0d: got state=%0d bits=%h, expected state=%0d bits=%h",
                 name, n, got.st, got, s.exp.st, s.exp);
      end
      n++;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic do_instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                          input logic brk, input int fwait, input int dwait);
    opcode = opc; funct3 = f3; env_break = brk;
    model_instr(opc, f3, fwait, dwait);
    run_queue(name);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t got;
    reset = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    @(posedge clk); #1;
    got = sample();
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL reset_hold: got %h expected 0", got);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cur_cause = 2'd0;
    push(base(ST_IDLE), rbit(), rbit());
    run_queue("reset_idle");
  endtask

  task automatic test_addi();
    do_instr("addi", OPC_OP_IMM, 3'b000, 1'b0, 2, 0);
  endtask

  task automatic test_load_store();
    do_instr("lw", OPC_LOAD, 3'b010, 1'b0, 0, 3);
    do_instr("sw", OPC_STORE, 3'b010, 1'b0, 1, 2);
  endtask

  task automatic test_branch_jump();
    do_instr("beq", OPC_BRANCH, 3'b000, 1'b0, 0, 0);
    do_instr("jal", OPC_JAL, 3'b000, 1'b0, 1, 0);
    do_instr("jalr", OPC_JALR, 3'b000, 1'b0, 0, 0);
    do_instr("lui", OPC_LUI, 3'b000, 1'b0, 0, 0);
    do_instr("auipc", OPC_AUIPC, 3'b000, 1'b0, 0, 0);
    do_instr("add", OPC_OP, 3'b000, 1'b0, 0, 0);
    do_instr("fence", OPC_FENCE, 3'b000, 1'b0, 0, 0);
  endtask

  task automatic test_traps();
    do_instr("illegal_7f", 7'h7F, 3'b000, 1'b0, 0, 0);
    do_instr("addi_hold1", OPC_OP_IMM, 3'b000, 1'b0, 0, 0);
    do_instr("ebreak", OPC_SYSTEM, 3'b000, 1'b1, 0, 0);
    do_instr("addi_hold3", OPC_OP_IMM, 3'b000, 1'b0, 1, 0);
    do_instr("sys_f3_100", OPC_SYSTEM, 3'b100, 1'b0, 0, 0);
    do_instr("ecall", OPC_SYSTEM, 3'b000, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    do_instr("fetch_timeout", OPC_OP_IMM, 3'b000, 1'b0, TMO, 0);
    do_instr("fetch_ack_at_limit", OPC_OP_IMM, 3'b000, 1'b0, TMO - 1, 0);
    do_instr("load_timeout", OPC_LOAD, 3'b010, 1'b0, 0, TMO);
    do_instr("store_ack_at_limit", OPC_STORE, 3'b010, 1'b0, 0, TMO - 1);
  endtask

  task automatic test_csr_illegal();
    do_instr("csrrwi", OPC_SYSTEM, 3'b101, 1'b0, 0, 0);
    do_instr("csrrs", OPC_SYSTEM, 3'b010, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_memory();
    obs_t got;
    opcode = OPC_LOAD; funct3 = 3'b010; env_break = 1'b0;
    model_instr(OPC_LOAD, 3'b010, 0, 3);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    run_queue("reset_mid_pre");
    dmem_ack = 1'b0;
    #2 reset = 1'b1;
    #1 got = sample();
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL reset_mid_memory: got %h expected 0", got);
    end
    cur_cause = 2'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    push(base(ST_IDLE), rbit(), rbit());
    run_queue("reset_mid_idle");
    do_instr("after_reset", OPC_OP_IMM, 3'b000, 1'b0, TMO - 1, 0);
  endtask

  task automatic test_random();
    logic [6:0] opc;
    int         idx;
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 11);
      opc = (idx == 11) ? rand_illegal() : legal_ops[idx];
      do_instr("random", opc, 3'($urandom_range(0, 7)), rbit(),
               $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1));
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_store();
    test_branch_jump();
    test_traps();
    test_reset_mid_memory();
    test_timeout();
    test_csr_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
